// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the instruction cache.
// Struct widths match the default 16-frame configuration.
package cpu_types_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_TAG_W = 26;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache.
// Same-cycle hits; misses fill one word through a two-state FSM.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t state_q, state_d;
  logic [29:0]   miss_q, miss_d;

  logic             valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS];
  logic [31:0]      data_q  [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             match;
  logic             fill;
  logic             unused_off;

  assign idx        = imemaddr[IDX_W+1:2];
  assign tag        = imemaddr[31:IDX_W+2];
  assign miss_idx   = miss_q[IDX_W-1:0];
  assign miss_tag   = miss_q[29:IDX_W];
  assign match      = valid_q[idx] && (tag_q[idx] == tag);
  assign imemload   = data_q[idx];
  assign unused_off = ^imemaddr[1:0];

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    fill    = 1'b0;
    ihit    = 1'b0;
    iREN    = 1'b0;
    iaddr   = '0;
    unique case (state_q)
      IDLE: begin
        ihit = imemREN & match;
        if (imemREN && !match) begin
          miss_d  = imemaddr[31:2];
          state_d = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_q, 2'b00};
        if (!iwait) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      miss_q  <= '0;
      for (int i = 0; i < SETS; i++) valid_q[i] <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      if (fill) valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; a fill racing RST is dropped.
  always_ff @(posedge CLK) begin
    if (!RST && fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= iload;
    end
  end

endmodule
